controle_escrita_banco: RTL and testbench
=========================================

// Module: controle_escrita_banco
// PURPOSE
//   Shares the single write port of banco_registradores between two writeback sources:
//   ULA (ALU result) and memoria (load data). Each source has a valid/ready handshake and a
//   one-entry holding buffer. An arbiter (round-robin by default) drives the write port
//   outputs, which connect directly to permisao_escrita, endereco_regd and dado_escrita.
// PARAMETERS
//   LARGURA_DADO  16  data width, matches banco_registradores
//   LARGURA_END   3   register address width (8 registers)
//   LARGURA_CONT  8   width of stall counter contador_esperas
// PORTS
//   clock             in   1             system clock, rising edge
//   reset             in   1             synchronous, active-high
//   ula_valido        in   1             ULA write request
//   ula_pronto        out  1             ULA buffer can accept
//   ula_end           in   LARGURA_END   ULA destination register
//   ula_dado          in   LARGURA_DADO  ULA write data
//   mem_valido        in   1             memoria write request
//   mem_pronto        out  1             memoria buffer can accept
//   mem_end           in   LARGURA_END   memoria destination register
//   mem_dado          in   LARGURA_DADO  memoria write data
//   permisao_escrita  out  1             write enable to register file
//   endereco_regd     out  LARGURA_END   write address to register file
//   dado_escrita      out  LARGURA_DADO  write data to register file
//   pendente          out  1             at least one buffer full
//   contador_esperas  out  LARGURA_CONT  saturating stall count
// BEHAVIOUR
//   - Reset (sync): both buffers empty; permisao_escrita/endereco_regd/dado_escrita = 0;
//     pendente = 0; contador_esperas = 0; round-robin pointer = "last grant was memoria".
//   - x_pronto = !buffer_x_full && !reset (combinational). Handshake fires on a rising edge
//     with x_valido && x_pronto; x_end/x_dado are captured into buffer_x. Requests seen while
//     reset=1 are dropped.
//   - Arbitration each edge over buffers full *before* the edge. One full -> grant it. Both
//     full -> grant the source not granted last; pointer updates only on a both-full grant.
//   - Grant at edge N: output regs load the granted buffer, and that buffer clears at edge N.
//     permisao_escrita = 1 for exactly the cycle after edge N; the register file writes at
//     edge N+1. No grant -> permisao_escrita = 0; endereco_regd/dado_escrita hold.
//   - Latency: accept at edge N, grant at edge N+1, register file captures at edge N+2.
//   - A buffer cannot be refilled on the edge it is granted (pronto is 0 while full), so
//     each source sustains at most one write per 2 cycles. The shared port can still write
//     every cycle when both sources are active.
//   - Destination 0: accepted and granted normally, but permisao_escrita stays 0 for that
//     grant (reg0 is reserved). The grant still consumes the cycle and clears the buffer.
//   - Order: per-source FIFO order holds. Cross-source order follows arbitration; same-address
//     hazards between sources are the issuer's responsibility.
//   - contador_esperas: +1 on each edge where (ula_valido && !ula_pronto) ||
//     (mem_valido && !mem_pronto), excluding reset. Saturates at 2^LARGURA_CONT-1.
//   - pendente = buffer_ula_full || buffer_mem_full (registered state, no comb. inputs).
//   - Reset mid-operation: buffered writes are discarded, never issued. An output write in
//     flight is dropped (permisao_escrita = 0 on the cycle after the reset edge).
// CONFIGURATION
//   PRIORIDADE_FIXA_EN defined: both-full conflict always grants memoria and the pointer is
//     unused (loads take priority).
//   Not defined: round-robin as above, ULA wins the first conflict after reset.
// TESTING
//   1 reset=1 for 5 cycles, inputs toggling -> all outputs 0, no handshake; pronto=1 after release
//   2 ULA only end=3 dado=16'h0033 accepted at edge N -> permisao=1,end=3,dado=0033 in cycle
//     after N+1; banco reads 16'h0033 at reg3
//   3 ULA end=1 dado=0011 and mem end=2 dado=0022 accepted on the same edge -> ULA written first,
//     memoria the next cycle; with PRIORIDADE_FIXA_EN memoria first; contador_esperas=0
//   4 mem end=0 dado=FFFF -> accepted, pendente 1 then 0, permisao_escrita stays 0, reg0 reads 0
//   5 both valido held high 300 cycles -> one write every cycle, grants alternate ULA/mem,
//     contador_esperas saturates at 255
//   6 both buffers full, reset pulsed 1 cycle -> no write issued, pendente=0, counter=0

Source files
------------

// File: rtl/controle_escrita_banco.sv
`default_nettype none
// ============================================================================
// Module      : controle_escrita_banco
// Description : Arbitrates the single banco_registradores write port between
//               the ULA and memoria writeback sources, each behind a one-entry
//               valid/ready buffer. Round-robin by default; defining
//               PRIORIDADE_FIXA_EN gives memoria fixed priority on conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_escrita_banco #(
    parameter int LARGURA_DADO = 16,
    parameter int LARGURA_END  = 3,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ula_valido,
    output logic                    ula_pronto,
    input  logic [LARGURA_END-1:0]  ula_end,
    input  logic [LARGURA_DADO-1:0] ula_dado,
    input  logic                    mem_valido,
    output logic                    mem_pronto,
    input  logic [LARGURA_END-1:0]  mem_end,
    input  logic [LARGURA_DADO-1:0] mem_dado,
    output logic                    permisao_escrita,
    output logic [LARGURA_END-1:0]  endereco_regd,
    output logic [LARGURA_DADO-1:0] dado_escrita,
    output logic                    pendente,
    output logic [LARGURA_CONT-1:0] contador_esperas
);

    localparam logic [LARGURA_END-1:0] c_end_zero = '0;

    logic                    r_ula_full;
    logic [LARGURA_END-1:0]  r_ula_end;
    logic [LARGURA_DADO-1:0] r_ula_dado;
    logic                    r_mem_full;
    logic [LARGURA_END-1:0]  r_mem_end;
    logic [LARGURA_DADO-1:0] r_mem_dado;

    logic                    r_permisao;
    logic [LARGURA_END-1:0]  r_end;
    logic [LARGURA_DADO-1:0] r_dado;
    logic [LARGURA_CONT-1:0] r_cont;

    logic                    w_aceita_ula;
    logic                    w_aceita_mem;
    logic                    w_grant_ula;
    logic                    w_grant_mem;
    logic                    w_conflito_ula;
    logic                    w_espera;
    logic [LARGURA_END-1:0]  w_sel_end;
    logic [LARGURA_DADO-1:0] w_sel_dado;

    assign ula_pronto   = !r_ula_full && !reset;
    assign mem_pronto   = !r_mem_full && !reset;
    assign w_aceita_ula = ula_valido && ula_pronto;
    assign w_aceita_mem = mem_valido && mem_pronto;
    assign w_espera     = (ula_valido && !ula_pronto) || (mem_valido && !mem_pronto);

`ifdef PRIORIDADE_FIXA_EN
    // Loads always win a conflict; no fairness state is needed.
    assign w_conflito_ula = 1'b0;
`else
    // 1 means memoria received the most recent conflict grant.
    logic r_ultimo_mem;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ultimo_mem <= 1'b1;
        end else if (r_ula_full && r_mem_full) begin
            r_ultimo_mem <= !r_ultimo_mem;
        end
    end

    assign w_conflito_ula = r_ultimo_mem;
`endif

    always_comb begin
        w_grant_ula = 1'b0;
        w_grant_mem = 1'b0;
        if (r_ula_full && r_mem_full) begin
            w_grant_ula = w_conflito_ula;
            w_grant_mem = !w_conflito_ula;
        end else begin
            w_grant_ula = r_ula_full;
            w_grant_mem = r_mem_full;
        end
    end

    assign w_sel_end  = w_grant_ula ? r_ula_end  : r_mem_end;
    assign w_sel_dado = w_grant_ula ? r_ula_dado : r_mem_dado;

    // Grant and accept are exclusive per buffer: accept needs it empty, grant needs it full.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ula_full <= 1'b0;
            r_ula_end  <= '0;
            r_ula_dado <= '0;
        end else if (w_grant_ula) begin
            r_ula_full <= 1'b0;
        end else if (w_aceita_ula) begin
            r_ula_full <= 1'b1;
            r_ula_end  <= ula_end;
            r_ula_dado <= ula_dado;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_full <= 1'b0;
            r_mem_end  <= '0;
            r_mem_dado <= '0;
        end else if (w_grant_mem) begin
            r_mem_full <= 1'b0;
        end else if (w_aceita_mem) begin
            r_mem_full <= 1'b1;
            r_mem_end  <= mem_end;
            r_mem_dado <= mem_dado;
        end
    end

    // Register 0 is reserved: the grant is consumed but never enables the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_permisao <= 1'b0;
            r_end      <= '0;
            r_dado     <= '0;
        end else if (w_grant_ula || w_grant_mem) begin
            r_permisao <= (w_sel_end != c_end_zero);
            r_end      <= w_sel_end;
            r_dado     <= w_sel_dado;
        end else begin
            r_permisao <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont <= '0;
        end else if (w_espera && !(&r_cont)) begin
            r_cont <= r_cont + 1'b1;
        end
    end

    assign permisao_escrita = r_permisao;
    assign endereco_regd    = r_end;
    assign dado_escrita     = r_dado;
    assign pendente         = r_ula_full || r_mem_full;
    assign contador_esperas = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_controle_escrita_banco.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_escrita_banco
// Description : Directed vector table plus multi-cycle sequences for the
//               writeback arbiter, with a small register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_escrita_banco;

`ifdef PRIORIDADE_FIXA_EN
    localparam bit FIXA = 1'b1;
`else
    localparam bit FIXA = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        ula_valido;
    logic        ula_pronto;
    logic [2:0]  ula_end;
    logic [15:0] ula_dado;
    logic        mem_valido;
    logic        mem_pronto;
    logic [2:0]  mem_end;
    logic [15:0] mem_dado;
    logic        permisao_escrita;
    logic [2:0]  endereco_regd;
    logic [15:0] dado_escrita;
    logic        pendente;
    logic [7:0]  contador_esperas;

    int checks = 0;
    int errors = 0;

    logic [15:0] regs [8];

    controle_escrita_banco #(
        .LARGURA_DADO(16),
        .LARGURA_END (3),
        .LARGURA_CONT(8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ula_valido      (ula_valido),
        .ula_pronto      (ula_pronto),
        .ula_end         (ula_end),
        .ula_dado        (ula_dado),
        .mem_valido      (mem_valido),
        .mem_pronto      (mem_pronto),
        .mem_end         (mem_end),
        .mem_dado        (mem_dado),
        .permisao_escrita(permisao_escrita),
        .endereco_regd   (endereco_regd),
        .dado_escrita    (dado_escrita),
        .pendente        (pendente),
        .contador_esperas(contador_esperas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: reg0 is hardwired to zero.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (permisao_escrita && endereco_regd != 3'd0) begin
            regs[endereco_regd] <= dado_escrita;
        end
    end

    typedef struct {
        logic        rst;
        logic        uv;
        logic [2:0]  ue;
        logic [15:0] ud;
        logic        mv;
        logic [2:0]  me;
        logic [15:0] md;
        logic        upr;
        logic        mpr;
        logic        we;
        logic [2:0]  wend;
        logic [15:0] wdado;
        logic        pend;
        logic [7:0]  cnt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tab [NVEC];

    function automatic vec_t mk(input logic rst, input logic uv, input logic [2:0] ue,
                                input logic [15:0] ud, input logic mv, input logic [2:0] me,
                                input logic [15:0] md, input logic upr, input logic mpr,
                                input logic we, input logic [2:0] wend, input logic [15:0] wdado,
                                input logic pend, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.uv = uv; v.ue = ue; v.ud = ud;
        v.mv = mv; v.me = me; v.md = md;
        v.upr = upr; v.mpr = mpr; v.we = we; v.wend = wend;
        v.wdado = wdado; v.pend = pend; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0]  e_end;
        logic [15:0] e_dado;
        int ruins;

        // rst uv ue ud mv me md | upr mpr we end dado pend cnt
        tab[0]  = mk(1, 1, 3'd3, 16'h1234, 1, 3'd5, 16'h5555, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
        tab[1]  = mk(1, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h6666, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
        tab[2]  = mk(1, 1, 3'd7, 16'h7777, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
        tab[3]  = mk(1, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
        tab[4]  = mk(1, 1, 3'd2, 16'h2222, 1, 3'd2, 16'h2222, 0, 0, 0, 3'd0, 16'h0000, 0, 0);
        tab[5]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 0, 0);
        tab[6]  = mk(0, 1, 3'd3, 16'h0033, 0, 3'd0, 16'h0000, 0, 1, 0, 3'd0, 16'h0000, 1, 0);
        tab[7]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'h0033, 0, 0);
        tab[8]  = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd3, 16'h0033, 0, 0);
        tab[9]  = mk(0, 1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, 0, 0, 0, 3'd3, 16'h0033, 1, 0);
        if (!FIXA) begin
            tab[10] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd1, 16'h0011, 1, 0);
            tab[11] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd2, 16'h0022, 0, 0);
            tab[12] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd2, 16'h0022, 0, 0);
            tab[13] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF, 1, 0, 0, 3'd2, 16'h0022, 1, 0);
        end else begin
            tab[10] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 1, 1, 3'd2, 16'h0022, 1, 0);
            tab[11] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd1, 16'h0011, 0, 0);
            tab[12] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd1, 16'h0011, 0, 0);
            tab[13] = mk(0, 0, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF, 1, 0, 0, 3'd1, 16'h0011, 1, 0);
        end
        tab[14] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'hFFFF, 0, 0);
        tab[15] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'hFFFF, 0, 0);
        tab[16] = mk(0, 1, 3'd4, 16'h0044, 0, 3'd0, 16'h0000, 0, 1, 0, 3'd0, 16'hFFFF, 1, 0);
        tab[17] = mk(0, 1, 3'd5, 16'h0055, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd4, 16'h0044, 0, 1);
        tab[18] = mk(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd4, 16'h0044, 0, 1);

        for (int i = 0; i < NVEC; i++) begin
            reset      = tab[i].rst;
            ula_valido = tab[i].uv;
            ula_end    = tab[i].ue;
            ula_dado   = tab[i].ud;
            mem_valido = tab[i].mv;
            mem_end    = tab[i].me;
            mem_dado   = tab[i].md;
            step();
            check($sformatf("v%0d ula_pronto", i), {31'd0, ula_pronto}, {31'd0, tab[i].upr});
            check($sformatf("v%0d mem_pronto", i), {31'd0, mem_pronto}, {31'd0, tab[i].mpr});
            check($sformatf("v%0d permisao", i), {31'd0, permisao_escrita}, {31'd0, tab[i].we});
            check($sformatf("v%0d endereco", i), {29'd0, endereco_regd}, {29'd0, tab[i].wend});
            check($sformatf("v%0d dado", i), {16'd0, dado_escrita}, {16'd0, tab[i].wdado});
            check($sformatf("v%0d pendente", i), {31'd0, pendente}, {31'd0, tab[i].pend});
            check($sformatf("v%0d contador", i), {24'd0, contador_esperas}, {24'd0, tab[i].cnt});
        end

        check("banco reg3", {16'd0, regs[3]}, 32'h0033);
        check("banco reg1", {16'd0, regs[1]}, 32'h0011);
        check("banco reg2", {16'd0, regs[2]}, 32'h0022);
        check("banco reg4", {16'd0, regs[4]}, 32'h0044);
        check("banco reg0", {16'd0, regs[0]}, 32'h0000);

        // Both sources saturating the port for 300 cycles.
        reset = 1; ula_valido = 0; mem_valido = 0;
        step();
        reset = 0;
        ula_valido = 1; ula_end = 3'd1; ula_dado = 16'hAAAA;
        mem_valido = 1; mem_end = 3'd2; mem_dado = 16'hBBBB;
        ruins = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k >= 2) begin
                if (((k % 2) == 0) != FIXA) begin
                    e_end = 3'd1; e_dado = 16'hAAAA;
                end else begin
                    e_end = 3'd2; e_dado = 16'hBBBB;
                end
                if (permisao_escrita !== 1'b1 || endereco_regd !== e_end || dado_escrita !== e_dado)
                    ruins++;
            end
            if (k == 100) check("contador k100", {24'd0, contador_esperas}, 32'd99);
        end
        check("alternancia ciclos ruins", ruins, 0);
        check("contador saturado", {24'd0, contador_esperas}, 32'd255);
        check("banco reg1 stream", {16'd0, regs[1]}, 32'hAAAA);
        check("banco reg2 stream", {16'd0, regs[2]}, 32'hBBBB);

        // Reset while a write is in flight and valids stay high.
        reset = 1;
        step();
        check("rst voo permisao", {31'd0, permisao_escrita}, 32'd0);
        check("rst voo pendente", {31'd0, pendente}, 32'd0);
        check("rst voo contador", {24'd0, contador_esperas}, 32'd0);
        check("rst voo endereco", {29'd0, endereco_regd}, 32'd0);
        check("rst voo ula_pronto", {31'd0, ula_pronto}, 32'd0);

        // Fill both buffers, then reset: nothing may be written.
        reset = 0;
        ula_valido = 1; ula_end = 3'd5; ula_dado = 16'h5555;
        mem_valido = 1; mem_end = 3'd6; mem_dado = 16'h6666;
        step();
        ula_valido = 0; mem_valido = 0;
        check("cheio pendente", {31'd0, pendente}, 32'd1);
        check("cheio ula_pronto", {31'd0, ula_pronto}, 32'd0);
        check("cheio mem_pronto", {31'd0, mem_pronto}, 32'd0);
        reset = 1;
        step();
        check("rst cheio permisao", {31'd0, permisao_escrita}, 32'd0);
        check("rst cheio pendente", {31'd0, pendente}, 32'd0);
        check("rst cheio contador", {24'd0, contador_esperas}, 32'd0);
        reset = 0;
        step();
        check("pos rst permisao", {31'd0, permisao_escrita}, 32'd0);
        check("pos rst pronto", {30'd0, ula_pronto, mem_pronto}, 32'd3);
        step();
        check("pos rst permisao 2", {31'd0, permisao_escrita}, 32'd0);
        check("banco reg5 descartado", {16'd0, regs[5]}, 32'h0000);
        check("banco reg6 descartado", {16'd0, regs[6]}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
